// File: rtl/item_keypad_entry_if.sv
// Keypad entry bundle: key input, item-select handshake and status/display outputs.
interface item_keypad_entry_if #(
  parameter int ITEM_ADDR_WIDTH = 10,
  parameter int MAX_DIGITS      = 3
);
  localparam int ACC_W = 4 * MAX_DIGITS;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic [3:0]                 key_code;
  logic                       key_valid;
  logic                       selection_valid;
  logic [ITEM_ADDR_WIDTH-1:0] item_select;
  logic                       item_select_valid;
  logic [ACC_W-1:0]           entry_value;
  logic [CNT_W-1:0]           digit_count;
  logic                       busy;
  logic                       entry_done;
  logic                       entry_error;
  logic                       entry_timeout;

  modport master (
    input  key_code, key_valid, selection_valid,
    output item_select, item_select_valid, entry_value, digit_count,
           busy, entry_done, entry_error, entry_timeout
  );

  modport slave (
    output key_code, key_valid, selection_valid,
    input  item_select, item_select_valid, entry_value, digit_count,
           busy, entry_done, entry_error, entry_timeout
  );
endinterface

// File: rtl/item_keypad_entry.sv
// Keypad entry controller: builds a decimal item number from key presses, range-checks it
// on ENTER and sends it over the item-select handshake with ack timeout and retry.
module item_keypad_entry #(
  parameter int ITEM_ADDR_WIDTH = 10,
  parameter int MAX_DIGITS      = 3,
  parameter int MAX_ITEM        = 999,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int ACK_WAIT        = 4,
  parameter int MAX_RETRY       = 2
) (
  input logic               clk,
  input logic               rstn,
  item_keypad_entry_if.master kp
);
  localparam int ACC_W = 4 * MAX_DIGITS;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int AW_W  = $clog2(ACK_WAIT);
  localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [3:0]       KEY_CLEAR = 4'hA;
  localparam logic [3:0]       KEY_ENTER = 4'hB;
  localparam logic [ACC_W-1:0] MAX_ACC   = ACC_W'(MAX_ITEM);

  typedef enum logic [1:0] {IDLE, ENTRY, SEND, WAIT_ACK} state_t;

  state_t                     state_q, state_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [TO_W-1:0]            idle_q, idle_d;
  logic [AW_W-1:0]            ackc_q, ackc_d;
  logic [RT_W-1:0]            retry_q, retry_d;
  logic [ITEM_ADDR_WIDTH-1:0] sel_q, sel_d;
  logic                       isv_q, isv_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       tmo_q, tmo_d;
  logic                       busy_q;
  logic                       is_digit;

  assign is_digit = (kp.key_code <= 4'd9);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    ackc_d  = ackc_q;
    retry_d = retry_q;
    sel_d   = sel_q;
    isv_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (kp.key_valid && is_digit) begin
          acc_d   = ACC_W'(kp.key_code);
          cnt_d   = CNT_W'(1);
          idle_d  = '0;
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (kp.key_valid) begin
          idle_d = '0;
          if (is_digit) begin
            if (cnt_q < CNT_W'(MAX_DIGITS)) begin
              acc_d = acc_q * ACC_W'(10) + ACC_W'(kp.key_code);
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (kp.key_code == KEY_CLEAR) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (kp.key_code == KEY_ENTER) begin
            if (acc_q > MAX_ACC) begin
              err_d   = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              retry_d = '0;
              state_d = SEND;
            end
          end
        end else if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          idle_d = idle_q + TO_W'(1);
        end
      end
      // The strobe and item are registered together as SEND hands over to WAIT_ACK,
      // so the ack window always starts on the strobe edge.
      SEND: begin
        sel_d   = ITEM_ADDR_WIDTH'(acc_q);
        isv_d   = 1'b1;
        ackc_d  = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (kp.selection_valid) begin
          done_d  = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          retry_d = '0;
          state_d = IDLE;
        end else if (ackc_q == AW_W'(ACK_WAIT - 1)) begin
          if (retry_q < RT_W'(MAX_RETRY)) begin
            retry_d = retry_q + RT_W'(1);
            state_d = SEND;
          end else begin
            err_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            retry_d = '0;
            state_d = IDLE;
          end
        end else begin
          ackc_d = ackc_q + AW_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      ackc_q  <= '0;
      retry_q <= '0;
      sel_q   <= '0;
      isv_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      ackc_q  <= ackc_d;
      retry_q <= retry_d;
      sel_q   <= sel_d;
      isv_q   <= isv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      busy_q  <= (state_d == SEND) || (state_d == WAIT_ACK);
    end
  end

  assign kp.item_select       = sel_q;
  assign kp.item_select_valid = isv_q;
  assign kp.entry_value       = acc_q;
  assign kp.digit_count       = cnt_q;
  assign kp.busy              = busy_q;
  assign kp.entry_done        = done_q;
  assign kp.entry_error       = err_q;
  assign kp.entry_timeout     = tmo_q;
endmodule

// File: tb/tb_item_keypad_entry.sv
// Bench for item_keypad_entry: event scoreboard fed by a decimal-entry reference model.
module tb_item_keypad_entry;
  localparam int IAW = 10, MD = 3, MAXI = 500, TO = 40, AW = 4, MR = 2;
  localparam int EV_SEL = 1, EV_DONE = 2, EV_ERR = 3, EV_TMO = 4;

  typedef struct { int kind; int val; int cyc; } ev_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sv;
  bit   ack_en = 1'b0;
  bit   prev_isv = 1'b0;
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;
  ev_t  sbq[$];

  int m_acc = 0, m_cnt = 0, m_last = 0;
  bit m_entry = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  item_keypad_entry_if #(.ITEM_ADDR_WIDTH(IAW), .MAX_DIGITS(MD)) kp();

  item_keypad_entry #(
    .ITEM_ADDR_WIDTH(IAW), .MAX_DIGITS(MD), .MAX_ITEM(MAXI),
    .TIMEOUT_CYCLES(TO), .ACK_WAIT(AW), .MAX_RETRY(MR)
  ) dut (.clk(clk), .rstn(rstn), .kp(kp));

  // Selection register with one cycle of latency, enabled per test.
  always @(posedge clk or negedge rstn)
    if (!rstn) sv <= 1'b0;
    else       sv <= ack_en && kp.item_select_valid;
  assign kp.selection_valid = sv;

  function automatic void check(string name, longint got, longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endfunction

  function automatic void push(int kind, int val, int c);
    ev_t e;
    e.kind = kind; e.val = val; e.cyc = c;
    sbq.push_back(e);
  endfunction

  function automatic void expect_ev(int kind, int val);
    ev_t e;
    if (sbq.size() == 0) begin
      check("unexpected_event", kind, 0);
      return;
    end
    e = sbq.pop_front();
    check("event_kind", kind, e.kind);
    check("event_cycle", cyc, e.cyc);
    if (kind == EV_SEL) check("item_select", val, e.val);
  endfunction

  // Monitor: every strobe the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (kp.item_select_valid) expect_ev(EV_SEL, int'(kp.item_select));
      if (kp.entry_done)        expect_ev(EV_DONE, 0);
      if (kp.entry_error)       expect_ev(EV_ERR, 0);
      if (kp.entry_timeout)     expect_ev(EV_TMO, 0);
      if (prev_isv && kp.item_select_valid) check("isv_back_to_back", 1, 0);
      if (int'(kp.entry_done) + int'(kp.entry_error) + int'(kp.entry_timeout) > 1)
        check("status_onehot", int'(kp.entry_done) + int'(kp.entry_error) + int'(kp.entry_timeout), 1);
    end
    prev_isv <= rstn && kp.item_select_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void model_clear();
    m_entry = 1'b0; m_acc = 0; m_cnt = 0;
  endfunction

  // Reference behaviour of one key outside the send handshake, sampled at edge k.
  function automatic void model_key(input int code, input int k);
    if (code <= 9) begin
      if (!m_entry) begin
        m_entry = 1'b1; m_acc = code; m_cnt = 1; m_last = k;
      end else if (m_cnt < MD) begin
        m_acc = m_acc * 10 + code; m_cnt++; m_last = k;
      end else begin
        push(EV_ERR, 0, k);
      end
    end else if (code == 10) begin
      model_clear();
    end else if (code == 11 && m_entry) begin
      push(EV_ERR, 0, k);
      model_clear();
    end
  endfunction

  task automatic press(input int code);
    int k;
    k = cyc + 1;
    model_key(code, k);
    kp.key_code = 4'(code); kp.key_valid = 1'b1;
    @(negedge clk);
    kp.key_valid = 1'b0;
    check("entry_value", kp.entry_value, m_acc);
    check("digit_count", kp.digit_count, m_cnt);
    check("busy_idle", kp.busy, 0);
  endtask

  // ENTER on a legal value: strobe one edge later, then ack or retries then error.
  task automatic send(input bit ack, input bit junk);
    int k, e, item;
    item = m_acc;
    ack_en = ack;
    k = cyc + 1;
    if (ack) begin
      push(EV_SEL, item, k + 1);
      e = k + 3;
      push(EV_DONE, 0, e);
    end else begin
      for (int i = 0; i <= MR; i++) push(EV_SEL, item, k + 1 + i * (AW + 1));
      e = k + 1 + MR * (AW + 1) + AW;
      push(EV_ERR, 0, e);
    end
    kp.key_code = 4'hB; kp.key_valid = 1'b1;
    @(negedge clk);
    kp.key_valid = 1'b0;
    while (cyc < e) begin
      check("busy_send", kp.busy, 1);
      check("entry_value_held", kp.entry_value, item);
      if (junk) begin
        kp.key_code = 4'($urandom_range(0, 15)); kp.key_valid = 1'b1;
      end
      @(negedge clk);
      kp.key_valid = 1'b0;
    end
    model_clear();
    check("busy_after", kp.busy, 0);
    check("entry_value_after", kp.entry_value, 0);
    check("digit_count_after", kp.digit_count, 0);
    check("item_select_held", kp.item_select, item);
    ack_en = 1'b0;
  endtask

  task automatic wait_timeout();
    int e;
    e = m_last + TO;
    push(EV_TMO, 0, e);
    while (cyc < e) @(negedge clk);
    model_clear();
    check("entry_value_tmo", kp.entry_value, 0);
    check("digit_count_tmo", kp.digit_count, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_isv"}, kp.item_select_valid, 0);
    check({tag, "_item"}, kp.item_select, 0);
    check({tag, "_value"}, kp.entry_value, 0);
    check({tag, "_count"}, kp.digit_count, 0);
    check({tag, "_busy"}, kp.busy, 0);
    check({tag, "_status"}, {kp.entry_done, kp.entry_error, kp.entry_timeout}, 0);
  endtask

  task automatic async_reset(input string tag);
    #2 rstn = 1'b0;
    #1 check_all_zero(tag);
    sbq.delete();
    model_clear();
    ack_en = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nd, act;
    kp.key_code = 4'h0; kp.key_valid = 1'b0;
    idle(3);
    check_all_zero("reset");
    #2 rstn = 1'b1;
    @(negedge clk);

    // Basic send with echoed ack.
    press(1); press(2); press(3);
    send(1'b1, 1'b0);
    // Overflow digit, then CLEAR.
    press(1); press(2); press(3); press(4); press(10);
    // Out of range on ENTER.
    press(7); press(7); press(7); press(11);
    // Inactivity timeout, then a key one cycle early reloads the counter.
    press(4); press(2); wait_timeout();
    press(4);
    while (cyc < m_last + TO - 2) @(negedge clk);
    press(2);
    wait_timeout();
    // No ack: three strobes then error; keys are dropped meanwhile.
    press(5);
    send(1'b0, 1'b1);
    // Reset mid-pulse of item_select_valid.
    press(6);
    k = cyc + 1;
    push(EV_SEL, 6, k + 1);
    kp.key_code = 4'hB; kp.key_valid = 1'b1;
    @(negedge clk); kp.key_valid = 1'b0;
    @(negedge clk);
    check("isv_before_reset", kp.item_select_valid, 1);
    async_reset("rst_pulse");
    // Reset during WAIT_ACK.
    press(8);
    k = cyc + 1;
    push(EV_SEL, 8, k + 1);
    kp.key_code = 4'hB; kp.key_valid = 1'b1;
    @(negedge clk); kp.key_valid = 1'b0;
    idle(3);
    check("busy_before_reset", kp.busy, 1);
    async_reset("rst_wait");
    idle(3 * (AW + 1));
    press(9);
    send(1'b1, 1'b0);

    // Randomized entries.
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) press($urandom_range(10, 15));
      nd = $urandom_range(1, 4);
      for (int i = 0; i < nd; i++) begin
        press($urandom_range(0, 9));
        idle($urandom_range(0, 3));
      end
      act = (nd == 4) ? $urandom_range(0, 1) : $urandom_range(0, 2);
      if (act == 0) begin
        if (m_acc <= MAXI) send($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        else press(11);
      end else if (act == 1) begin
        press(10);
      end else begin
        wait_timeout();
      end
      idle($urandom_range(0, 2));
    end

    idle(10);
    check("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
